// File: rtl/controle_display_mux_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// active-low output constants, FSM state encoding and a width helper.
package controle_display_mux_pkg;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic       ANODO_OFF   = 1'b1;
    localparam logic       DP_OFF      = 1'b1;

    typedef enum logic {
        APAGADO = 1'b0,
        ATIVO   = 1'b1
    } estado_t;

    // Counter width for n states; never below 1 so N_DIGITOS=1 still yields a legal vector.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/controle_display_mux_7seg.sv
// BCD to 7-segment decoder, segments {g,f,e,d,c,b,a}, active low.
// Codes above 9 leave every segment off.
module bcd_para_7seg
    import controle_display_mux_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segmentos
);

    always_comb begin
        unique case (bcd)
            4'd0:    segmentos = 7'b1000000;
            4'd1:    segmentos = 7'b1111001;
            4'd2:    segmentos = 7'b0100100;
            4'd3:    segmentos = 7'b0110000;
            4'd4:    segmentos = 7'b0011001;
            4'd5:    segmentos = 7'b0010010;
            4'd6:    segmentos = 7'b0000010;
            4'd7:    segmentos = 7'b1111000;
            4'd8:    segmentos = 7'b0000000;
            4'd9:    segmentos = 7'b0010000;
            default: segmentos = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/controle_display_mux.sv
// Time-multiplexed scan controller for N common-anode digits sharing one decoder.
// Latches a per-frame snapshot, blanks the start of each slot, suppresses leading zeros.
module controle_display_mux
    import controle_display_mux_pkg::*;
#(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int T_APAGADO     = 500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     habilita,
    input  logic [4*N_DIGITOS-1:0]   digitos,
    input  logic [N_DIGITOS-1:0]     pontos,
    input  logic                     supressao_zeros,
    output logic [6:0]               display,
    output logic                     dp,
    output logic [N_DIGITOS-1:0]     anodos
);

    localparam int IW = clog2(N_DIGITOS);
    localparam int CW = clog2(DIV_VARREDURA);

    localparam logic [CW-1:0] ULTIMO_CONT    = CW'(DIV_VARREDURA - 1);
    localparam logic [CW-1:0] LIMITE_APAGADO = CW'(T_APAGADO);
    localparam logic [IW-1:0] ULTIMO_IDX     = IW'(N_DIGITOS - 1);

    logic [CW-1:0]            contador_q, contador_d;
    logic [IW-1:0]            indice_q, indice_d;
    estado_t                  estado_q, estado_d;
    logic                     captura;
    logic [4*N_DIGITOS-1:0]   snapshot;
    logic [N_DIGITOS-1:0]     pontos_snap;

    logic [N_DIGITOS-1:0]     suprimido;
    logic                     acima_zero;
    logic                     zero_i;
    logic [3:0]               digito_sel;
    logic                     ponto_sel;
    logic                     supr_sel;
    logic [N_DIGITOS-1:0]     anodo_sel;
    logic [6:0]               segmentos;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        contador_d = contador_q;
        indice_d   = indice_q;
        estado_d   = estado_q;
        captura    = 1'b0;
        if (!habilita) begin
            contador_d = '0;
            indice_d   = '0;
            estado_d   = APAGADO;
        end else begin
            // The frame snapshot is only taken at the very start of digit 0's slot.
            captura = (contador_q == '0) && (indice_q == '0);
            if (contador_q == ULTIMO_CONT) begin
                contador_d = '0;
                indice_d   = (indice_q == ULTIMO_IDX) ? '0 : indice_q + 1'b1;
            end else begin
                contador_d = contador_q + 1'b1;
            end
            estado_d = (contador_d < LIMITE_APAGADO) ? APAGADO : ATIVO;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            contador_q  <= '0;
            indice_q    <= '0;
            estado_q    <= APAGADO;
            snapshot    <= '0;
            pontos_snap <= '0;
        end else begin
            contador_q <= contador_d;
            indice_q   <= indice_d;
            estado_q   <= estado_d;
            if (captura) begin
                snapshot    <= digitos;
                pontos_snap <= pontos;
            end
        end
    end

    // Walk from the most significant digit down; a digit is blank only while all above are blank too.
    always_comb begin
        suprimido  = '0;
        acima_zero = 1'b1;
        zero_i     = 1'b0;
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            zero_i = (snapshot[i*4 +: 4] == 4'd0) && !pontos_snap[i];
            if (i != 0) suprimido[i] = supressao_zeros && zero_i && acima_zero;
            acima_zero = acima_zero && zero_i;
        end
    end

    always_comb begin
        digito_sel = 4'd0;
        ponto_sel  = 1'b0;
        supr_sel   = 1'b0;
        anodo_sel  = {N_DIGITOS{ANODO_OFF}};
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (indice_q == IW'(i)) begin
                digito_sel   = snapshot[i*4 +: 4];
                ponto_sel    = pontos_snap[i];
                supr_sel     = suprimido[i];
                anodo_sel[i] = ~ANODO_OFF;
            end
        end
    end

    bcd_para_7seg u_decodificador (
        .bcd       (digito_sel),
        .segmentos (segmentos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            anodos  <= {N_DIGITOS{ANODO_OFF}};
            display <= SEG_APAGADO;
            dp      <= DP_OFF;
        end else if (habilita && (estado_q == ATIVO) && !supr_sel) begin
            anodos  <= anodo_sel;
            display <= segmentos;
            dp      <= ~ponto_sel;
        end else begin
            anodos  <= {N_DIGITOS{ANODO_OFF}};
            display <= SEG_APAGADO;
            dp      <= DP_OFF;
        end
    end

endmodule

// File: doc/controle_display_mux.md
Name: controle_display_mux

Overview:
Time-multiplexed scan controller that shares one BCD-to-7-segment decoder (bcd_para_7seg) across N common-anode digits of the cronometro display. It latches a frame-coherent snapshot of all BCD digits, then selects one digit per scan slot and drives its anode. Each slot starts with a blanking interval to suppress ghosting. Optional leading-zero suppression and per-digit decimal point are supported. It sits between the stopwatch counters and the board display pins.

Parameters:
N_DIGITOS, 4, number of multiplexed digits (1..8)
DIV_VARREDURA, 50000, clock cycles per digit slot (>=2)
T_APAGADO, 500, blank cycles at the start of each slot (1 <= T_APAGADO < DIV_VARREDURA)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
habilita  in  1  1 = scan running; 0 = display dark
digitos  in  4*N_DIGITOS  BCD digits; bits [3:0] = digit 0 (rightmost, least significant)
pontos  in  N_DIGITOS  decimal point request per digit, 1 = lit
supressao_zeros  in  1  1 = blank leading zeros
display  out  7  segments [a..g], active low
dp  out  1  decimal point, active low
anodos  out  N_DIGITOS  digit enables, active low; bit i = digit i

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: anodos all 1, display 7'b1111111, dp 1. Internally: indice 0, contador 0, snapshot 0, estado APAGADO.
- All outputs are registered. Outputs in cycle t reflect the (estado, indice, snapshot) of cycle t-1.
- Slot counter contador runs 0..DIV_VARREDURA-1. At DIV_VARREDURA-1 it wraps to 0 and indice increments mod N_DIGITOS (N-1 -> 0).
- Frame snapshot: when habilita=1, contador=0 and indice=0, snapshot <= digitos and pontos_snap <= pontos. Inputs are ignored at all other times, so a frame never shows mixed values.
- FSM (2 states):
  - APAGADO (contador < T_APAGADO): anodos all 1, display 7'b1111111, dp 1.
  - ATIVO (contador >= T_APAGADO): anodo[indice] = 0 and all others 1. display = decoder(snapshot digit indice). dp = ~pontos_snap[indice].
- Leading-zero suppression: digit i is suppressed when supressao_zeros=1, i != 0, snapshot digit i = 0, pontos_snap[i] = 0, and every digit j > i is also zero with pontos_snap[j] = 0. A suppressed digit keeps all anodes high during its ATIVO window. Digit 0 is never suppressed.
- Invalid BCD (>9): the decoder default applies (all segments off). The anode is still driven and dp still honoured.
- Frame period = N_DIGITOS*DIV_VARREDURA cycles. Each digit is lit for DIV_VARREDURA-T_APAGADO cycles per frame.
- habilita=0: contador and indice are forced to 0 and estado to APAGADO, so outputs go dark on the next cycle. When habilita returns to 1, scanning restarts at digit 0 with a fresh snapshot on that first cycle.
- rst mid-slot: same as the reset values on the next edge. rst has priority over habilita.
- Snapshot latency is hidden because T_APAGADO >= 1: the first ATIVO cycle already uses the new snapshot.

Decomposition:
- Shared package: active-low constants (SEG_APAGADO = 7'b1111111, ANODO_OFF), the FSM state enum {APAGADO, ATIVO}, and width helper clog2(N_DIGITOS) for indice.
- Sub-module: one instance of bcd_para_7seg, fed from the snapshot mux; its output is registered here.

Test Plan:
(All use N_DIGITOS=4, DIV_VARREDURA=8, T_APAGADO=2; frame = 32 cycles.)
1. Reset: hold rst 3 cycles with habilita=1 and digitos=16'h1234 -> anodos=4'b1111, display=7'b1111111, dp=1 throughout, and for 2 cycles after release.
2. Scan order, digitos=16'h1234, supressao_zeros=0:
   - Slot 0: 2 blank cycles, then 6 cycles of anodos=4'b1110, display=7'b0011001.
   - Slot 1: anodos=4'b1101, display=7'b0110000.
   - Slot 2: 4'b1011 / 7'b0100100.
   - Slot 3: 4'b0111 / 7'b1111001.
   - Pattern repeats every 32 cycles.
3. Leading zeros, supressao_zeros=1:
   - 16'h0070: slots 3 and 2 show anodos=4'b1111; slot 1 shows 7'b1111000; slot 0 shows 7'b1000000.
   - 16'h0000: only digit 0 is lit.
   - 16'h0000 with pontos=4'b0100: digits 2, 1 and 0 are lit; digit 2 has dp=0.
4. Frame coherency: digitos=16'h1111, changed to 16'h2222 during slot 1 -> slots 1-3 still show 7'b1111001; the next frame shows 7'b0100100 in all slots.
5. habilita and rst mid-slot:
   - Drop habilita during the ATIVO window of slot 2 -> anodos=4'b1111 on the next cycle.
   - Re-raise habilita -> 2 blank cycles, then the digit 0 window.
   - Pulse rst during slot 3 -> same dark-then-restart-at-digit-0 response.
6. Invalid digit plus dp: digitos=16'h0A00, pontos=4'b0100, supressao_zeros=0 -> slot 2 shows anodos=4'b1011, display=7'b1111111, dp=0; dp=1 in all other slots.
